// File: rtl/inv_seq_pkg.sv
// Shared definitions for the inverter toggle sequencer.
// Holds the sequencer state encoding and the default field widths.
// Imported by inv_toggle_seq.
package inv_seq_pkg;

   localparam int HALF_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;
   localparam int MIS_W_DEF  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/inv_toggle_seq_hold_timer.sv
// hold_timer: loadable down-counter with a zero flag; load wins over dec.
// Ports: clk, rst_n (async active-low), load/load_val, dec, zero.
// Latency: zero reflects the registered count; stops at zero, no backpressure.
module hold_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/inv_toggle_seq.sv
// inv_toggle_seq: drives an inverter under test with a timed toggle train and
// counts responses that are not the complement of the driven level.
// Ports: start/abort/half_period/num_toggles in, dut_in/dut_out to the DUT,
// busy/done/mismatch_cnt status. Toggle k lands k*max(half_period,1) edges
// after the accepted start; done is a one-cycle pulse; no backpressure.
module inv_toggle_seq
   import inv_seq_pkg::*;
#(
   parameter int HALF_W = HALF_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int MIS_W  = MIS_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [HALF_W-1:0] half_period,
   input  logic [CNT_W-1:0]  num_toggles,
   output logic              dut_in,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic [MIS_W-1:0]  mismatch_cnt
);

   state_e             state_q, state_d;
   logic               dut_in_q, dut_in_d;
   logic [MIS_W-1:0]   mis_q, mis_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [HALF_W-1:0]  half_q, half_d;

   logic               tmr_load;
   logic [HALF_W-1:0]  tmr_load_val;
   logic               tmr_dec;
   logic               tmr_zero;

   // Timer reload is max(h,1)-1, so half_period 0 behaves as 1.
   logic [HALF_W-1:0]  reload_new;
   logic [HALF_W-1:0]  reload_run;

   assign reload_new = (half_period == '0) ? '0 : half_period - HALF_W'(1);
   assign reload_run = (half_q == '0)      ? '0 : half_q - HALF_W'(1);

   hold_timer #(
      .W (HALF_W)
   ) u_hold_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      dut_in_d     = dut_in_q;
      mis_d        = mis_q;
      rem_d        = rem_q;
      half_d       = half_q;
      tmr_load     = 1'b0;
      tmr_load_val = reload_run;
      tmr_dec      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mis_d = '0;
               if (num_toggles != '0) begin
                  half_d       = half_period;
                  rem_d        = num_toggles;
                  tmr_load     = 1'b1;
                  tmr_load_val = reload_new;
                  state_d      = ST_HOLD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_HOLD: begin
            if (abort) begin
               // Abort beats a toggle due on the same edge: no compare, no toggle.
               dut_in_d = 1'b0;
               state_d  = ST_IDLE;
            end else if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else begin
               // A healthy inverter output is the complement of the level held.
               if ((dut_out == dut_in_q) && (mis_q != {MIS_W{1'b1}})) begin
                  mis_d = mis_q + MIS_W'(1);
               end
               dut_in_d = ~dut_in_q;
               rem_d    = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  tmr_load = 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         dut_in_q <= 1'b0;
         mis_q    <= '0;
         rem_q    <= '0;
         half_q   <= '0;
      end else begin
         state_q  <= state_d;
         dut_in_q <= dut_in_d;
         mis_q    <= mis_d;
         rem_q    <= rem_d;
         half_q   <= half_d;
      end
   end

   assign dut_in       = dut_in_q;
   assign busy         = (state_q == ST_HOLD);
   assign done         = (state_q == ST_DONE);
   assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_inv_toggle_seq.sv
// Bench for inv_toggle_seq: directed vector table, a mid-run reset sequence
// and randomized runs checked cycle by cycle against a toggle-schedule model.
// Runs with a 2-bit mismatch counter so saturation is reachable.
module tb_inv_toggle_seq;

   localparam int HALF_W  = 8;
   localparam int CNT_W   = 8;
   localparam int MIS_W   = 2;
   localparam int MIS_MAX = (1 << MIS_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [HALF_W-1:0] half_period = '0;
   logic [CNT_W-1:0]  num_toggles = '0;
   logic              dut_in;
   logic              dut_out;
   logic              busy;
   logic              done;
   logic [MIS_W-1:0]  mismatch_cnt;

   // Inverter model: 0 ideal, 1 stuck at 0, 2 stuck at 1, 3 random response.
   int   out_mode = 0;
   logic drv = 1'b0;
   assign dut_out = (out_mode == 0) ? ~dut_in : drv;

   int   total = 0;
   int   bad   = 0;
   logic m_dut_in = 1'b0;
   int   m_cnt = 0;

   inv_toggle_seq #(
      .HALF_W (HALF_W),
      .CNT_W  (CNT_W),
      .MIS_W  (MIS_W)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .half_period  (half_period),
      .num_toggles  (num_toggles),
      .dut_in       (dut_in),
      .dut_out      (dut_out),
      .busy         (busy),
      .done         (done),
      .mismatch_cnt (mismatch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Observed tuple {dut_in, busy, done, mismatch_cnt} against the model.
   task automatic chk_cycle(input string name, input logic eb, input logic ed);
      chk(name, {dut_in, busy, done, mismatch_cnt}, {m_dut_in, eb, ed, MIS_W'(m_cnt)});
   endtask

   // One sequence: toggle k lands on edge k*H after the start edge (edge 0).
   // ab>0 aborts on that edge (must lie within 1..n*H).
   task automatic run_seq(input int hp, input int n, input int mode, input int ab);
      int   h, last, endt, allow;
      logic running, ab_now, d_exp, resp;
      h     = (hp == 0) ? 1 : hp;
      last  = n * h;
      endt  = (ab > 0) ? ab + 1 : last + 1;
      allow = (ab > 0) ? ab : last + 1;
      @(negedge clk);
      out_mode    = mode;
      drv         = (mode == 2) ? 1'b1 : (mode == 3) ? 1'($urandom % 2) : 1'b0;
      start       = 1'b1;
      abort       = 1'b0;
      half_period = HALF_W'(hp);
      num_toggles = CNT_W'(n);
      @(posedge clk);
      m_cnt   = 0;
      running = (n > 0);
      #1 chk_cycle("start_edge", running, (n == 0));
      for (int t = 1; t <= endt; t++) begin
         @(negedge clk);
         // Start and config noise while busy/done must be ignored.
         start       = (t <= allow) ? 1'($urandom % 2) : 1'b0;
         half_period = HALF_W'($urandom);
         num_toggles = CNT_W'($urandom);
         ab_now      = (t == ab) || ((ab == 0) && (t == last + 1) && ($urandom % 2 == 1));
         abort       = ab_now;
         if (mode == 3) drv = 1'($urandom % 2);
         @(posedge clk);
         d_exp = 1'b0;
         if (running) begin
            if (ab_now) begin
               running  = 1'b0;
               m_dut_in = 1'b0;
            end else if (t % h == 0) begin
               resp = (mode == 0) ? ~m_dut_in : drv;
               if ((resp == m_dut_in) && (m_cnt < MIS_MAX)) m_cnt++;
               m_dut_in = ~m_dut_in;
               if (t == last) begin
                  running = 1'b0;
                  d_exp   = 1'b1;
               end
            end
         end
         #1 chk_cycle("seq_cycle", running, d_exp);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   typedef struct {
      int   hp;
      int   n;
      int   mode;
      int   ab;
      int   e_mis;
      logic e_din;
   } vec_t;

   vec_t tbl [9];

   initial begin
      int hp_r, n_r, ab_r;

      tbl[0] = '{hp: 3, n: 4,  mode: 0, ab: 0,  e_mis: 0, e_din: 1'b0}; // normal run
      tbl[1] = '{hp: 3, n: 4,  mode: 1, ab: 0,  e_mis: 2, e_din: 1'b0}; // stuck at 0
      tbl[2] = '{hp: 0, n: 0,  mode: 0, ab: 0,  e_mis: 0, e_din: 1'b0}; // zero count
      tbl[3] = '{hp: 5, n: 10, mode: 1, ab: 12, e_mis: 1, e_din: 1'b0}; // abort mid-hold
      tbl[4] = '{hp: 5, n: 4,  mode: 2, ab: 10, e_mis: 0, e_din: 1'b0}; // abort beats toggle
      tbl[5] = '{hp: 2, n: 3,  mode: 2, ab: 0,  e_mis: 1, e_din: 1'b1}; // odd count ends high
      tbl[6] = '{hp: 0, n: 0,  mode: 1, ab: 0,  e_mis: 0, e_din: 1'b1}; // zero count keeps level
      tbl[7] = '{hp: 1, n: 1,  mode: 0, ab: 0,  e_mis: 0, e_din: 1'b0}; // single toggle
      tbl[8] = '{hp: 0, n: 20, mode: 1, ab: 0,  e_mis: 3, e_din: 1'b0}; // saturation, hp=0

      #12;
      chk_cycle("reset_state", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_seq(tbl[i].hp, tbl[i].n, tbl[i].mode, tbl[i].ab);
         chk($sformatf("vec%0d_final", i), {31'd0, dut_in} << MIS_W | 32'(mismatch_cnt),
             {31'd0, tbl[i].e_din} << MIS_W | 32'(tbl[i].e_mis));
      end

      // Abort while idle changes nothing; count held until next start.
      @(negedge clk);
      abort = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk_cycle("idle_abort", 1'b0, 1'b0);
      @(negedge clk);
      abort = 1'b0;

      // Reset in the middle of a run: hp=2, n=8, stuck at 0.
      @(negedge clk);
      out_mode    = 1;
      drv         = 1'b0;
      start       = 1'b1;
      half_period = 8'd2;
      num_toggles = 8'd8;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1 chk("pre_reset", {27'd0, dut_in, busy, done, mismatch_cnt}, 32'b1_1_0_10);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {27'd0, dut_in, busy, done, mismatch_cnt}, 32'd0);
      m_dut_in = 1'b0;
      m_cnt    = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_seq(3, 2, 0, 0);

      // Randomized runs against the schedule model.
      for (int r = 0; r < 40; r++) begin
         hp_r = $urandom_range(0, 4);
         n_r  = $urandom_range(0, 7);
         ab_r = 0;
         if ((n_r > 0) && ($urandom % 4 == 0))
            ab_r = $urandom_range(1, n_r * ((hp_r == 0) ? 1 : hp_r));
         run_seq(hp_r, n_r, $urandom_range(0, 3), ab_r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inv_toggle_seq.md
INV_TOGGLE_SEQ -- requirements
Module: inv_toggle_seq

Interface
REQ-001 Parameter HALF_W, default 8: width of the half-period field.
REQ-002 Parameter CNT_W, default 8: width of the toggle-count field.
REQ-003 Parameter MIS_W, default 8: width of the mismatch counter.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: launch a sequence; honoured only in IDLE.
REQ-008 Port abort, input, 1: synchronous abort of a running sequence.
REQ-009 Port half_period, input, HALF_W: hold time of each dut_in level, in cycles.
REQ-010 Port num_toggles, input, CNT_W: number of dut_in toggles to issue.
REQ-011 Port dut_in, output, 1: drives the inverter under test.
REQ-012 Port dut_out, input, 1: inverter response.
REQ-013 Port busy, output, 1: high while in HOLD.
REQ-014 Port done, output, 1: one-cycle pulse at normal completion.
REQ-015 Port mismatch_cnt, output, MIS_W: count of failed response checks.

Function
REQ-016 States SHALL be IDLE, HOLD and DONE; reset state is IDLE.
REQ-017 IDLE, start=1, num_toggles!=0: latch config, load hold counter with max(half_period,1)-1, load remaining with num_toggles, clear mismatch_cnt, go to HOLD.
REQ-018 IDLE, start=1, num_toggles==0: clear mismatch_cnt, go to DONE; dut_in unchanged.
REQ-019 HOLD, counter!=0: decrement counter; dut_in held.
REQ-020 HOLD, counter==0: compare dut_out with ~dut_in; if unequal, increment mismatch_cnt, saturating at all-ones.
REQ-021 On the same edge, dut_in SHALL invert and remaining SHALL decrement.
REQ-022 If remaining was 1 on that edge, go to DONE; otherwise reload the counter and stay in HOLD.
REQ-023 Consequence: the k-th toggle occurs k*max(half_period,1) cycles after the start edge.
REQ-024 half_period==0 SHALL behave exactly as half_period==1.
REQ-025 DONE SHALL assert done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-026 start in HOLD or DONE SHALL be ignored; latched config SHALL NOT change mid-sequence.
REQ-027 abort in HOLD: next state IDLE, dut_in forced to 0, mismatch_cnt held, no done pulse.
REQ-028 abort has priority over a toggle on the same edge.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 mismatch_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, dut_in=0, busy=0, done=0, mismatch_cnt=0, counters=0, from any state including mid-HOLD.
REQ-032 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 Package inv_seq_pkg SHALL hold the state enum and default width constants.
REQ-034 One sub-module, hold_timer, SHALL implement the loadable down-counter with a zero flag.

Verification
REQ-035 Normal run: half_period=3, num_toggles=4, ideal inverter -> dut_in toggles at cycles 3, 6, 9, 12 after start; done pulses at cycle 13; mismatch_cnt=0; dut_in ends at 0.
REQ-036 Stuck DUT: same config, dut_out tied 0 -> mismatch_cnt=2.
REQ-037 Zero count: num_toggles=0 -> done pulses the cycle after start; dut_in unchanged; no busy.
REQ-038 Abort: half_period=5, num_toggles=10, abort at cycle 12 -> IDLE next cycle; dut_in=0; no done pulse; mismatch_cnt held.
REQ-039 Reset mid-run: rst_n low at cycle 7 -> all outputs at reset values asynchronously; a new start is accepted after release.
REQ-040 Saturation: MIS_W=2, dut_out stuck, num_toggles=20 -> mismatch_cnt=3, no wrap; half_period=0 -> toggles every cycle.
